chip_cmd_sequencer: RTL
=======================

Name: chip_cmd_sequencer

Overview:
- Upstream stage of the DRAM chip model: accepts decoded DDR4 commands (ACT/RD/WR/PRE) one at a time.
- Tracks the open row per bank and expands each RD/WR into a BL-beat burst on the chip's per-bank row/column/rd_o_wr/dqin arrays.
- Collects the chip's per-bank dqout back into a single read-data stream with a valid strobe.
- Sits between the channel command decoder and the chip instance.

Parameters:
- BGWIDTH, 2, bank-group select width.
- BAWIDTH, 2, bank-in-group select width.
- ADDRWIDTH, 17, row address width.
- COLWIDTH, 10, column address width.
- DEVICE_WIDTH, 4, DQ bits per device.
- BL, 8, burst length; power of two, 2..2**COLWIDTH.
- RDLAT, 1, cycles from column presentation to valid chip dqout; 0..7.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd  in  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE; others treated as NOP.
- bg  in  BGWIDTH  target bank group.
- ba  in  BAWIDTH  target bank.
- addr  in  ADDRWIDTH  row (ACT) or start column in [COLWIDTH-1:0] (RD/WR).
- wr_data  in  DEVICE_WIDTH  write beat data, sampled during write beats.
- rd_data  out  DEVICE_WIDTH  read beat data.
- rd_valid  out  1  rd_data valid.
- cmd_err  out  1  one-cycle pulse on an illegal command.
- rd_o_wr  out  [BANKGROUPS][BANKSPERGROUP] x 1  per bank; 1 = write beat.
- dqin  out  [BANKGROUPS][BANKSPERGROUP] x DEVICE_WIDTH  per-bank write data.
- dqout  in  [BANKGROUPS][BANKSPERGROUP] x DEVICE_WIDTH  per-bank read data from the chip.
- row  out  [BANKGROUPS][BANKSPERGROUP] x ADDRWIDTH  per-bank open row.
- column  out  [BANKGROUPS][BANKSPERGROUP] x COLWIDTH  per-bank column.

Behaviour:
- Reset values (async): every row, column, rd_o_wr and dqin = 0; all banks closed; FSM = IDLE; rd_valid = 0; rd_data = 0; cmd_err = 0; latency pipe cleared. cmd_ready = 1 while in IDLE.
- FSM states: IDLE, BURST.
- cmd_ready = (state == IDLE). A command is accepted on a clock edge where cmd_valid && cmd_ready.
- ACT:
  - Closed bank: row[bg][ba] <= addr and the bank is marked open; visible the cycle after acceptance.
  - Open bank: ignored and cmd_err pulses.
- PRE: marks the bank closed. row[bg][ba] keeps its value. PRE to a closed bank is a legal no-op.
- RD/WR:
  - Closed bank: cmd_err pulses, no burst, state stays IDLE.
  - Open bank: latch bg/ba/start column/direction, beat counter = 0, go to BURST.
- BURST:
  - Beats occupy cycles N+1..N+BL after accept edge N.
  - Beat i column = {start[COLWIDTH-1:log2BL], (start[log2BL-1:0] + i) mod BL}, i.e. sequential wrap within the BL-aligned block.
  - Only the target bank's column updates; other banks hold.
  - On the last beat's edge, return to IDLE. cmd_ready goes high the cycle after the last beat.
- Write beats: rd_o_wr[bg][ba] = 1 and dqin[bg][ba] = wr_data (combinational pass-through). All other dqin = 0; all other rd_o_wr = 0.
- Read beats: rd_o_wr stays 0. A valid bit and bank index enter an RDLAT-deep shift pipe. When the bit emerges: rd_valid = 1 and rd_data = registered dqout of that bank. The first rd_valid is at cycle N+1+RDLAT+1 relative to accept edge N (one capture register). There are no bubbles within a burst.
- Read data from one burst may still be draining while the next command is accepted; the pipe is independent of the FSM.
- cmd_err is registered and high for exactly one cycle per illegal command.
- Reset mid-burst: immediate return to reset values; the partial burst is discarded and its read data is never emitted.

Decomposition:
- Shared package (ddr_pkg):
  - cmd_t enum (NOP, ACT, RD, WR, PRE).
  - Width constants BGWIDTH, BAWIDTH, ADDRWIDTH, COLWIDTH, DEVICE_WIDTH.
  - Function burst_col(start, i, BL).
- Sub-module rd_latency_pipe: parameterised valid plus bank-index shift pipe of depth RDLAT, with async clear.

Test Plan:
- Reset → all row/column/dqin = 0, rd_o_wr = 0, cmd_ready = 1, rd_valid = 0, cmd_err = 0.
- ACT bg=1, ba=2, addr=0x1ABC → next cycle row[1][2] = 0x1ABC; a second ACT to the same bank → cmd_err one-cycle pulse, row unchanged.
- WR bg=1, ba=2, col=0x005, BL=8, wr_data=0..7 → column[1][2] sequence 5,6,7,0,1,2,3,4; rd_o_wr[1][2] = 1 for 8 cycles; dqin[1][2] follows wr_data; cmd_ready = 0 for those 8 cycles.
- RD same address with a chip model attached, RDLAT=1 → rd_valid high for 8 consecutive cycles starting 3 cycles after accept; rd_data = 0..7 in beat order.
- RD to closed bank bg=0, ba=0 → cmd_err pulse, no column change, cmd_ready stays 1; PRE to closed bank → no error.
- rst asserted at WR beat 3 → all outputs zero asynchronously; after release cmd_ready = 1, all banks closed (RD to bg=1, ba=2 gives cmd_err).

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared DDR4 chip-model definitions: command encoding, default widths and the burst column helper.
package ddr_pkg;

  localparam int BGWIDTH      = 2;
  localparam int BAWIDTH      = 2;
  localparam int ADDRWIDTH    = 17;
  localparam int COLWIDTH     = 10;
  localparam int DEVICE_WIDTH = 4;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4
  } cmd_t;

  // Beat i of a burst wraps sequentially inside the bl-aligned column block.
  function automatic int burst_col(input int start, input int i, input int bl);
    return (start & ~(bl - 1)) | ((start + i) & (bl - 1));
  endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// Read-beat valid/bank-index delay line of DEPTH cycles (DEPTH=0 is a wire).
// No backpressure: one entry shifts in every cycle; async clear drops in-flight beats.
module rd_latency_pipe #(
  parameter int DEPTH = 1,
  parameter int IDXW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  input  logic [IDXW-1:0] in_idx,
  output logic            out_vld,
  output logic [IDXW-1:0] out_idx
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_vld = in_vld;
      assign out_idx = in_idx;
    end else begin : g_shift
      logic [DEPTH-1:0] vld_sr;
      logic [IDXW-1:0]  idx_sr [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_sr <= '0;
          for (int i = 0; i < DEPTH; i++) idx_sr[i] <= '0;
        end else begin
          vld_sr[0] <= in_vld;
          idx_sr[0] <= in_idx;
          for (int i = 1; i < DEPTH; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            idx_sr[i] <= idx_sr[i-1];
          end
        end
      end

      assign out_vld = vld_sr[DEPTH-1];
      assign out_idx = idx_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/chip_cmd_sequencer.sv
// Expands ACT/RD/WR/PRE into per-bank BL-beat bursts; read data returns RDLAT+1 cycles after each beat.
// Backpressure: cmd_ready drops for the BL burst cycles; the read return path never stalls.
module chip_cmd_sequencer #(
  parameter  int BGWIDTH       = ddr_pkg::BGWIDTH,
  parameter  int BAWIDTH       = ddr_pkg::BAWIDTH,
  parameter  int ADDRWIDTH     = ddr_pkg::ADDRWIDTH,
  parameter  int COLWIDTH      = ddr_pkg::COLWIDTH,
  parameter  int DEVICE_WIDTH  = ddr_pkg::DEVICE_WIDTH,
  parameter  int BL            = 8,
  parameter  int RDLAT         = 1,
  localparam int BANKGROUPS    = 2 ** BGWIDTH,
  localparam int BANKSPERGROUP = 2 ** BAWIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd,
  input  logic [BGWIDTH-1:0]      bg,
  input  logic [BAWIDTH-1:0]      ba,
  input  logic [ADDRWIDTH-1:0]    addr,
  input  logic [DEVICE_WIDTH-1:0] wr_data,
  output logic [DEVICE_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    cmd_err,
  output logic                    rd_o_wr [BANKGROUPS][BANKSPERGROUP],
  output logic [DEVICE_WIDTH-1:0] dqin    [BANKGROUPS][BANKSPERGROUP],
  input  logic [DEVICE_WIDTH-1:0] dqout   [BANKGROUPS][BANKSPERGROUP],
  output logic [ADDRWIDTH-1:0]    row     [BANKGROUPS][BANKSPERGROUP],
  output logic [COLWIDTH-1:0]     column  [BANKGROUPS][BANKSPERGROUP]
);

  import ddr_pkg::*;

  localparam int BKW   = BGWIDTH + BAWIDTH;
  localparam int NBANK = 1 << BKW;
  localparam int CNTW  = (BL > 1) ? $clog2(BL) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [BGWIDTH-1:0]  bg;
    logic [BAWIDTH-1:0]  ba;
    logic [COLWIDTH-1:0] start;
    logic                is_wr;
  } burst_t;

  state_t          state, state_nxt;
  burst_t          cur;
  logic [CNTW-1:0] beat;
  logic [NBANK-1:0] bank_open;
  logic [BKW-1:0]  sel_idx;
  logic            sel_open, accept, last_beat, illegal, start_burst;
  logic            beat_vld, pipe_vld;
  logic [BKW-1:0]  pipe_idx;

  assign sel_idx   = {bg, ba};
  assign sel_open  = bank_open[sel_idx];
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign last_beat = (beat == CNTW'(BL - 1));
  assign beat_vld  = (state == BURST) && !cur.is_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    illegal     = 1'b0;
    start_burst = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd)
            ACT:     illegal = sel_open;
            RD, WR: begin
              if (sel_open) begin
                start_burst = 1'b1;
                state_nxt   = BURST;
              end else begin
                illegal = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      BURST: if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_open <= '0;
      cur       <= '0;
      beat      <= '0;
      cmd_err   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          row[g][b]    <= '0;
          column[g][b] <= '0;
        end
      end
    end else begin
      cmd_err <= illegal;
      if (accept && (cmd == ACT) && !sel_open) begin
        row[bg][ba]        <= addr;
        bank_open[sel_idx] <= 1'b1;
      end
      // Row register survives PRE so the chip still sees the last opened row.
      if (accept && (cmd == PRE)) bank_open[sel_idx] <= 1'b0;
      if (start_burst) begin
        cur.bg       <= bg;
        cur.ba       <= ba;
        cur.start    <= addr[COLWIDTH-1:0];
        cur.is_wr    <= (cmd == WR);
        beat         <= '0;
        column[bg][ba] <= addr[COLWIDTH-1:0];
      end else if ((state == BURST) && !last_beat) begin
        beat <= beat + 1'b1;
        column[cur.bg][cur.ba] <= COLWIDTH'(burst_col(int'(cur.start), int'(beat) + 1, BL));
      end
      rd_valid <= pipe_vld;
      rd_data  <= pipe_vld ? dqout[pipe_idx[BKW-1:BAWIDTH]][pipe_idx[BAWIDTH-1:0]] : '0;
    end
  end

  always_comb begin
    for (int g = 0; g < BANKGROUPS; g++) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        rd_o_wr[g][b] = 1'b0;
        dqin[g][b]    = '0;
      end
    end
    if ((state == BURST) && cur.is_wr) begin
      rd_o_wr[cur.bg][cur.ba] = 1'b1;
      dqin[cur.bg][cur.ba]    = wr_data;
    end
  end

  rd_latency_pipe #(
    .DEPTH (RDLAT),
    .IDXW  (BKW)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (beat_vld),
    .in_idx  ({cur.bg, cur.ba}),
    .out_vld (pipe_vld),
    .out_idx (pipe_idx)
  );

endmodule
